// File: rtl/can_tx_bitstream.sv
// CAN transmit bit-stream engine: serializes SOF..CRC with bit stuffing, appends the fixed tail,
// and checks every sampled bus bit for arbitration loss, bit errors and a missing ACK.
module can_tx_bitstream #(
  parameter int FRAME_W  = 98,
  parameter int ARB_BITS = 12
) (
  input  logic               i_can_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic [6:0]         i_stuff_len,
  input  logic               i_samp_tick,
  input  logic               i_rx_bit,
  output logic               o_tx_bit,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_arb_lost,
  output logic               o_bit_err,
  output logic               o_ack_err
);

  typedef enum logic [1:0] {S_IDLE, S_STUFF, S_TAIL} state_t;

  state_t             state, state_n;
  logic [FRAME_W-1:0] shreg, shreg_n;
  logic [6:0]         len_q, len_n, idx, idx_n;
  logic [2:0]         run, run_n;
  logic               stuff_q, stuff_n;
  logic [3:0]         tail_idx, tail_n;
  logic               tx_n, done_n, arb_n, berr_n, aerr_n;
  logic [6:0]         len_clamped;
  logic               mismatch, in_arb, next_frame_bit;

  assign len_clamped    = (i_stuff_len > 7'(FRAME_W)) ? 7'(FRAME_W) : i_stuff_len;
  assign mismatch       = (i_rx_bit != o_tx_bit);
  assign in_arb         = !stuff_q && (idx >= 7'd1) && (idx <= 7'(ARB_BITS));
  assign next_frame_bit = shreg[FRAME_W-2];
  assign o_busy         = (state != S_IDLE);

  // shreg[FRAME_W-1] always holds the frame bit at idx; a stuff bit leaves it in place.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    len_n   = len_q;
    idx_n   = idx;
    run_n   = run;
    stuff_n = stuff_q;
    tail_n  = tail_idx;
    tx_n    = o_tx_bit;
    done_n  = 1'b0;
    arb_n   = 1'b0;
    berr_n  = 1'b0;
    aerr_n  = 1'b0;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (i_start) begin
          shreg_n = i_frame;
          len_n   = len_clamped;
          idx_n   = 7'd0;
          run_n   = 3'd1;
          stuff_n = 1'b0;
          tail_n  = 4'd0;
          if (len_clamped == 7'd0) begin
            state_n = S_TAIL;
          end else begin
            state_n = S_STUFF;
            tx_n    = i_frame[FRAME_W-1];
          end
        end
      end
      S_STUFF: begin
        if (i_samp_tick) begin
          if (mismatch) begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
            if (in_arb && o_tx_bit && !i_rx_bit) arb_n = 1'b1;
            else berr_n = 1'b1;
          end else if (run == 3'd5) begin
            tx_n    = ~o_tx_bit;
            stuff_n = 1'b1;
            run_n   = 3'd1;
          end else if ((idx + 7'd1) >= len_q) begin
            state_n = S_TAIL;
            tx_n    = 1'b1;
            tail_n  = 4'd0;
            stuff_n = 1'b0;
          end else begin
            shreg_n = shreg << 1;
            tx_n    = next_frame_bit;
            idx_n   = idx + 7'd1;
            stuff_n = 1'b0;
            run_n   = (next_frame_bit == o_tx_bit) ? run + 3'd1 : 3'd1;
          end
        end
      end
      S_TAIL: begin
        tx_n = 1'b1;
        if (i_samp_tick) begin
          if (tail_idx == 4'd1) begin
            if (i_rx_bit) begin
              aerr_n  = 1'b1;
              state_n = S_IDLE;
            end else begin
              tail_n = tail_idx + 4'd1;
            end
          end else if (!i_rx_bit) begin
            berr_n  = 1'b1;
            state_n = S_IDLE;
          end else if (tail_idx == 4'd9) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            tail_n = tail_idx + 4'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_can_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      len_q      <= 7'd0;
      idx        <= 7'd0;
      run        <= 3'd0;
      stuff_q    <= 1'b0;
      tail_idx   <= 4'd0;
      o_tx_bit   <= 1'b1;
      o_done     <= 1'b0;
      o_arb_lost <= 1'b0;
      o_bit_err  <= 1'b0;
      o_ack_err  <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      len_q      <= len_n;
      idx        <= idx_n;
      run        <= run_n;
      stuff_q    <= stuff_n;
      tail_idx   <= tail_n;
      o_tx_bit   <= tx_n;
      o_done     <= done_n;
      o_arb_lost <= arb_n;
      o_bit_err  <= berr_n;
      o_ack_err  <= aerr_n;
    end
  end

endmodule

// File: tb/tb_can_tx_bitstream.sv
// Bench for can_tx_bitstream: a queue-based model expands each frame into its expected bus bits,
// then the bench plays the bus back (with injected faults) and checks tx bits and status pulses.
module tb_can_tx_bitstream;
  localparam int FW = 98;

  logic          clk = 1'b0;
  logic          rst, start, tick, rx_bit;
  logic [FW-1:0] frame;
  logic [6:0]    stuff_len;
  logic          tx_bit, busy, done, arb_lost, bit_err, ack_err;

  int errors = 0;
  int checks = 0;

  bit q_bit[$];
  bit q_stf[$];
  int q_idx[$];

  can_tx_bitstream #(.FRAME_W(FW), .ARB_BITS(12)) dut (
    .i_can_clk(clk), .i_reset(rst), .i_start(start), .i_frame(frame),
    .i_stuff_len(stuff_len), .i_samp_tick(tick), .i_rx_bit(rx_bit),
    .o_tx_bit(tx_bit), .o_busy(busy), .o_done(done), .o_arb_lost(arb_lost),
    .o_bit_err(bit_err), .o_ack_err(ack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected bus sequence: after five equal bits comes their complement; tail is ten recessive bits.
  task automatic build(input logic [FW-1:0] f, input int len);
    int run;
    bit prev, b;
    q_bit.delete(); q_stf.delete(); q_idx.delete();
    run = 0;
    prev = 1'b1;
    for (int i = 0; i < len; i++) begin
      b = f[FW-1-i];
      q_bit.push_back(b); q_stf.push_back(1'b0); q_idx.push_back(i);
      run = (i > 0 && b == prev) ? run + 1 : 1;
      prev = b;
      if (run == 5) begin
        q_bit.push_back(~b); q_stf.push_back(1'b1); q_idx.push_back(i);
        prev = ~b;
        run = 1;
      end
    end
    for (int t = 0; t < 10; t++) begin
      q_bit.push_back(1'b1); q_stf.push_back(1'b0); q_idx.push_back(-1);
    end
  endtask

  // kind: 0 none, 1 frame index arg forced to fval, 2 first stuff bit inverted,
  //       3 tail index arg forced to fval, 4 random position inverted
  task automatic run_frame(input string tag, input logic [FW-1:0] f, input logic [6:0] len_in,
                           input int kind, input int arg, input bit fval, input bit ack_val,
                           input bit poke, input int reset_pos);
    int len, n, ack_pos, fpos, outcome, gap;
    bit tx, rx;
    logic [3:0] exp_st;
    len = (int'(len_in) > FW) ? FW : int'(len_in);
    build(f, len);
    n = q_bit.size();
    ack_pos = n - 10 + 1;
    fpos = -1;
    case (kind)
      1: for (int p = 0; p < n; p++) if (fpos < 0 && !q_stf[p] && q_idx[p] == arg) fpos = p;
      2: for (int p = 0; p < n; p++) if (fpos < 0 && q_stf[p]) fpos = p;
      3: fpos = n - 10 + arg;
      4: fpos = $urandom_range(0, n - 1);
      default: fpos = -1;
    endcase
    if ((kind == 2 || kind == 4) && fpos >= 0) fval = ~q_bit[fpos];
    @(negedge clk);
    start = 1'b1; frame = f; stuff_len = len_in;
    @(negedge clk);
    start = 1'b0; frame = ~f;
    chk({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
    for (int p = 0; p < n; p++) begin
      gap = poke ? $urandom_range(1, 2) : $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if (poke) begin start = 1'b1; stuff_len = 7'd3; end
        @(negedge clk);
        start = 1'b0;
      end
      tx = q_bit[p];
      chk({tag, "_tx"}, {31'd0, tx_bit}, {31'd0, tx});
      chk({tag, "_quiet"}, {27'd0, busy, done, arb_lost, bit_err, ack_err}, 32'h10);
      if (p == reset_pos) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, "_rst_out"}, {26'd0, tx_bit, busy, done, arb_lost, bit_err, ack_err}, 32'h20);
        return;
      end
      rx = tx;
      if (p == ack_pos) rx = ack_val;
      if (p == fpos) rx = fval;
      outcome = 0;
      if (p == ack_pos) begin
        if (rx) outcome = 4;
      end else if (rx != tx) begin
        outcome = (!q_stf[p] && q_idx[p] >= 1 && q_idx[p] <= 12 && tx && !rx) ? 2 : 3;
      end
      if (outcome == 0 && p == n - 1) outcome = 1;
      tick = 1'b1; rx_bit = rx;
      @(negedge clk);
      tick = 1'b0; rx_bit = 1'($urandom_range(0, 1));
      if (outcome != 0) begin
        case (outcome)
          1: exp_st = 4'b1000;
          2: exp_st = 4'b0100;
          3: exp_st = 4'b0010;
          default: exp_st = 4'b0001;
        endcase
        chk({tag, "_status"}, {28'd0, done, arb_lost, bit_err, ack_err}, {28'd0, exp_st});
        chk({tag, "_end_busy_tx"}, {30'd0, busy, tx_bit}, 32'd1);
        @(negedge clk);
        chk({tag, "_pulse_1cyc"}, {27'd0, busy, done, arb_lost, bit_err, ack_err}, 32'd0);
        return;
      end
    end
  endtask

  initial begin
    logic [FW-1:0] f;
    bit b;
    rst = 1'b1; start = 1'b0; tick = 1'b0; rx_bit = 1'b1; frame = '0; stuff_len = 7'd0;
    repeat (3) @(negedge clk);
    chk("reset_out", {26'd0, tx_bit, busy, done, arb_lost, bit_err, ack_err}, 32'h20);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_out", {26'd0, tx_bit, busy, done, arb_lost, bit_err, ack_err}, 32'h20);

    f = {1'b0, 11'h123, 1'b0, 85'd0};
    run_frame("t1", f, 7'd19, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    f = {6'b000001, 92'd0};
    run_frame("t2", f, 7'd10, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    f = {1'b0, 11'h1A3, 1'b0, 85'd0};
    run_frame("t3", f, 7'd19, 1, 4, 1'b0, 1'b0, 1'b0, -1);
    f = {1'b0, 11'h7C0, 1'b0, 85'd0};
    run_frame("t4a", f, 7'd19, 2, 0, 1'b0, 1'b0, 1'b0, -1);
    run_frame("t4b", f, 7'd19, 3, 8, 1'b0, 1'b0, 1'b0, -1);
    run_frame("t4c", f, 7'd19, 1, 3, 1'b1, 1'b0, 1'b0, -1);
    run_frame("t5a", f, 7'd19, 0, 0, 1'b0, 1'b1, 1'b1, -1);
    f = {1'b0, 11'h555, 86'h2AAA_FFFF_0000_1234_5678};
    run_frame("t5b", f, 7'd127, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    run_frame("t5c", f, 7'd0, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    f = {1'b0, 11'h123, 1'b0, 85'd0};
    run_frame("t6a", f, 7'd19, 0, 0, 1'b0, 1'b0, 1'b0, 8);
    run_frame("t6b", f, 7'd19, 0, 0, 1'b0, 1'b0, 1'b0, -1);

    for (int r = 0; r < 24; r++) begin
      b = 1'($urandom_range(0, 1));
      for (int i = 0; i < FW; i++) begin
        if ($urandom_range(0, 3) == 0) b = ~b;
        f[i] = b;
      end
      run_frame("rnd", f, 7'($urandom_range(0, 127)), ($urandom_range(0, 1) == 0) ? 0 : 4,
                0, 1'b0, 1'($urandom_range(0, 7) == 0), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
